id_imm_stage: RTL and testbench

//  Decode-stage immediate controller between the fetch stage and EX. Takes fetched
//  {PC, instruction} over a valid/ready handshake and decodes the opcode to an

---
 rtl/id_imm_stage.sv | 212 +++++++++++++++++++++
 tb/tb_id_imm_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_imm_stage.sv
// Decode-stage immediate controller.
// Accepts {pc, instr} from fetch, decodes the immediate type and the sign-extended
// immediate, flags unsupported opcodes and registers the result into a two-entry
// (main + skid) buffer toward EX. The ready output is a flop, so stalls from EX
// never ripple combinationally back to fetch.
module id_imm_stage #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [31:0]     out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal
);

    // Immediate type codes; 0 means "no immediate" (R-type or illegal).
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  imm_type;
        logic        illegal;
    } dec_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [31:0]     imm;
        logic [2:0]      imm_type;
        logic            illegal;
    } entry_t;

    localparam int     ENTRY_W    = $bits(entry_t);
    localparam entry_t ENTRY_ZERO = entry_t'({ENTRY_W{1'b0}});

    // Opcode to immediate-type decode with the core's bit-selection rules.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.imm      = 32'd0;
        d.imm_type = IMM_NONE;
        d.illegal  = 1'b0;
        case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                d.imm_type = IMM_I;
                d.imm      = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0100011: begin
                d.imm_type = IMM_S;
                d.imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                d.imm_type = IMM_B;
                d.imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                d.imm_type = IMM_U;
                d.imm      = {instr[31:12], 12'h000};
            end
            7'b1101111: begin
                d.imm_type = IMM_J;
                d.imm      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            end
            7'b0110011: begin
                d.illegal = 1'b0;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    occ_t   state_r;
    occ_t   state_nxt_s;
    entry_t main_r;
    entry_t skid_r;
    entry_t in_entry_s;
    dec_t   dec_s;
    logic   in_ready_r;
    logic   out_valid_r;
    logic   accept_s;
    logic   consume_s;
    logic   load_main_in_s;
    logic   load_main_skid_s;
    logic   load_skid_s;

    // Decode the presented instruction and assemble the candidate entry.
    always_comb begin
        dec_s      = decode(in_instr);
        in_entry_s = '{pc: in_pc, instr: in_instr, imm: dec_s.imm,
                       imm_type: dec_s.imm_type, illegal: dec_s.illegal};
    end

    assign accept_s  = in_valid & in_ready_r;
    assign consume_s = out_valid_r & out_ready;

    // Occupancy next-state and buffer load controls; flush overrides everything.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s    = ST_ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && consume_s) begin
                        state_nxt_s    = ST_ONE;
                        load_main_in_s = 1'b1;
                    end else if (accept_s) begin
                        state_nxt_s = ST_TWO;
                        load_skid_s = 1'b1;
                    end else if (consume_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (consume_s) begin
                        state_nxt_s      = ST_ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state plus the registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            in_ready_r  <= (state_nxt_s != ST_TWO);
        end
    end

    // Main entry: reloaded from input or from skid, otherwise held stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r <= ENTRY_ZERO;
        end else if (load_main_in_s) begin
            main_r <= in_entry_s;
        end else if (load_main_skid_s) begin
            main_r <= skid_r;
        end else begin
            main_r <= main_r;
        end
    end

    // Skid entry: captures an accept while EX stalls, cleared when promoted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_r <= ENTRY_ZERO;
        end else if (load_skid_s) begin
            skid_r <= in_entry_s;
        end else if (load_main_skid_s) begin
            skid_r <= ENTRY_ZERO;
        end else begin
            skid_r <= skid_r;
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_pc       = main_r.pc;
    assign out_instr    = main_r.instr;
    assign out_imm      = main_r.imm;
    assign out_imm_type = main_r.imm_type;
    assign out_illegal  = main_r.illegal;

endmodule

// File: tb/tb_id_imm_stage.sv
// Bench for id_imm_stage: table of decode vectors streamed back-to-back, then
// hand-written sequences for back-pressure, flush and asynchronous reset.
module tb_id_imm_stage;

    localparam logic [2:0] T_N = 3'd0;
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_S = 3'd2;
    localparam logic [2:0] T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4;
    localparam logic [2:0] T_J = 3'd5;
    localparam int NVEC = 16;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_imm;
    logic [2:0]  out_imm_type;
    logic        out_illegal;

    int   n_vec;
    int   n_bad;
    vec_t vecs [NVEC];

    id_imm_stage #(.PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_imm(out_imm), .out_imm_type(out_imm_type),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_entry(input string name, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] imm, input logic [2:0] typ, input logic ill);
        chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, ".pc"}, out_pc, pc);
        chk({name, ".instr"}, out_instr, instr);
        chk({name, ".imm"}, out_imm, imm);
        chk({name, ".type"}, {29'd0, out_imm_type}, {29'd0, typ});
        chk({name, ".illegal"}, {31'd0, out_illegal}, {31'd0, ill});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, T_I, 1'b0}; // addi -1
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, T_S, 1'b0}; // sw -4
        vecs[2]  = '{32'h123450B7, 32'h12345000, T_U, 1'b0}; // lui
        vecs[3]  = '{32'h0000007F, 32'h00000000, T_N, 1'b1}; // illegal
        vecs[4]  = '{32'h002081B3, 32'h00000000, T_N, 1'b0}; // add
        vecs[5]  = '{32'hFE000EE3, 32'hFFFFFFFC, T_B, 1'b0}; // beq -4
        vecs[6]  = '{32'h00208463, 32'h00000008, T_B, 1'b0}; // beq +8
        vecs[7]  = '{32'h008000EF, 32'h00000008, T_J, 1'b0}; // jal +8
        vecs[8]  = '{32'hFFDFF06F, 32'hFFFFFFFC, T_J, 1'b0}; // jal -4
        vecs[9]  = '{32'h00001097, 32'h00001000, T_U, 1'b0}; // auipc
        vecs[10] = '{32'h00412083, 32'h00000004, T_I, 1'b0}; // lw +4
        vecs[11] = '{32'h000080E7, 32'h00000000, T_I, 1'b0}; // jalr
        vecs[12] = '{32'h80000073, 32'hFFFFF800, T_I, 1'b0}; // system, imm -2048
        vecs[13] = '{32'h0FF0000F, 32'h000000FF, T_I, 1'b0}; // fence
        vecs[14] = '{32'h0000005B, 32'h00000000, T_N, 1'b1}; // illegal
        vecs[15] = '{32'h40000033, 32'h00000000, T_N, 1'b0}; // sub

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 32'd0; in_instr = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.pc", out_pc, 32'd0);
        chk("rst.instr", out_instr, 32'd0);
        chk("rst.imm", out_imm, 32'd0);
        chk("rst.type", {29'd0, out_imm_type}, 32'd0);
        chk("rst.illegal", {31'd0, out_illegal}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Table: streamed back-to-back with EX always ready.
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            offer(32'h100 + 32'(4 * i), vecs[i].instr);
            tick();
            chk_entry($sformatf("vec%0d", i), 32'h100 + 32'(4 * i), vecs[i].instr,
                      vecs[i].imm, vecs[i].typ, vecs[i].ill);
            chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain.out_valid", {31'd0, out_valid}, 32'd0);

        // Back-pressure: three offers with EX stalled, two accepted.
        out_ready = 1'b0;
        offer(32'h200, 32'hFFF00093);
        tick();
        chk("bp1.in_ready", {31'd0, in_ready}, 32'd1);
        chk_entry("bp1", 32'h200, 32'hFFF00093, 32'hFFFFFFFF, T_I, 1'b0);
        offer(32'h204, 32'hFE112E23);
        tick();
        chk("bp2.in_ready", {31'd0, in_ready}, 32'd0);
        chk_entry("bp2", 32'h200, 32'hFFF00093, 32'hFFFFFFFF, T_I, 1'b0);
        offer(32'h208, 32'h123450B7);
        tick();
        chk("bp3.in_ready", {31'd0, in_ready}, 32'd0);
        chk_entry("bp3", 32'h200, 32'hFFF00093, 32'hFFFFFFFF, T_I, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp4.in_ready", {31'd0, in_ready}, 32'd1);
        chk_entry("bp4", 32'h204, 32'hFE112E23, 32'hFFFFFFFC, T_S, 1'b0);
        tick();
        chk("bp5.out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp5.in_ready", {31'd0, in_ready}, 32'd1);

        // Flush while full, with a new instruction offered in the flush cycle.
        out_ready = 1'b0;
        offer(32'h300, 32'h00001097);
        tick();
        offer(32'h304, 32'h008000EF);
        tick();
        chk("fl0.in_ready", {31'd0, in_ready}, 32'd0);
        offer(32'h308, 32'hFE000EE3);
        flush = 1'b1;
        tick();
        chk("fl1.out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl1.in_ready", {31'd0, in_ready}, 32'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl2.out_valid", {31'd0, out_valid}, 32'd0);
        // Stage must still work normally after the flush.
        offer(32'h30C, 32'h00412083);
        tick();
        chk_entry("fl3", 32'h30C, 32'h00412083, 32'h00000004, T_I, 1'b0);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset while full.
        out_ready = 1'b0;
        offer(32'h400, 32'hFFDFF06F);
        tick();
        offer(32'h404, 32'h0000007F);
        tick();
        chk("ar0.in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar1.out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar1.in_ready", {31'd0, in_ready}, 32'd1);
        chk("ar1.pc", out_pc, 32'd0);
        chk("ar1.instr", out_instr, 32'd0);
        chk("ar1.imm", out_imm, 32'd0);
        chk("ar1.type", {29'd0, out_imm_type}, 32'd0);
        chk("ar1.illegal", {31'd0, out_illegal}, 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("ar2.out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("ar3.out_valid", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
